// File: rtl/wb_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_merge                                                        |
// | Purpose  : Multi-channel writeback merge stage. Each of NCH producers       |
// |            pushes results into its own FIFO. A round-robin arbiter pops at  |
// |            most one entry per cycle and drives the single register-file    |
// |            write port. Link results (pc+8) are resolved at enqueue and      |
// |            writes to register 0 are suppressed.                             |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk       in   1             rising-edge clock                           |
// |   rst_n     in   1             synchronous active-low reset                |
// |   flush     in   1             synchronous clear of all buffered results   |
// |   in_valid  in   NCH           per-channel result valid                    |
// |   in_ready  out  NCH           per-channel space available                 |
// |   in_regf   in   NCH*REGF_W    destination register, ch i at i*REGF_W      |
// |   in_data   in   NCH*DATA_W    result data, same packing                   |
// |   in_link   in   NCH           1 = write pc+8 instead of in_data           |
// |   in_pc     in   NCH*ADDR_W    instruction pc, same packing                |
// |   rf_we     out  1             register file write enable (registered)     |
// |   rf_waddr  out  REGF_W        register file write address (registered)    |
// |   rf_wdata  out  DATA_W        register file write data (registered)       |
// |   busy      out  1             any FIFO non-empty or rf_we high            |
// |   stall_cnt out  32            saturating stall counter (WB_STALL_CNT_EN)  |
// +----------------------------------------------------------------------------+
// | Optional feature macro: WB_STALL_CNT_EN                                    |
// |   When defined, adds stall_cnt: counts edges where any channel presents    |
// |   in_valid while its FIFO is full. Saturates, ignores flush.               |
// +----------------------------------------------------------------------------+
module wb_merge #(
  parameter int NCH    = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REGF_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NCH-1:0]          in_valid,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH*REGF_W-1:0]   in_regf,
  input  logic [NCH*DATA_W-1:0]   in_data,
  input  logic [NCH-1:0]          in_link,
  input  logic [NCH*ADDR_W-1:0]   in_pc,
  output logic                    rf_we,
  output logic [REGF_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic                    busy
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NCH > 1) ? $clog2(NCH) : 1;

  // ---------------------------------------------------------------------------
  // Cross-channel signals
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]        nonempty;
  logic [NCH-1:0]        pop_vec;
  logic [NCH*REGF_W-1:0] head_regf_flat;
  logic [NCH*DATA_W-1:0] head_data_flat;

  // Arbiter results
  logic                  have_win;
  logic [RR_W-1:0]       win_idx;
  logic [REGF_W-1:0]     win_regf;
  logic [DATA_W-1:0]     win_data;

  // Output / pointer state
  logic [RR_W-1:0]       rr_ptr_q,   rr_ptr_d;
  logic                  rf_we_q,    rf_we_d;
  logic [REGF_W-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DATA_W-1:0] mem_data_q [DEPTH];
      logic [REGF_W-1:0] mem_regf_q [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]  count_q,  count_d;
      logic              ready;
      logic              push;
      logic              pop;
      logic [DATA_W-1:0] pc_ext;
      logic [DATA_W-1:0] enq_data;

      // No pass-through: a full FIFO refuses input even if it pops this cycle.
      assign ready        = (count_q < CNT_W'(DEPTH));
      assign in_ready[gi] = ready;
      assign nonempty[gi] = (count_q != '0);
      assign pop          = pop_vec[gi];

      assign head_regf_flat[gi*REGF_W +: REGF_W] = mem_regf_q[rd_ptr_q];
      assign head_data_flat[gi*DATA_W +: DATA_W] = mem_data_q[rd_ptr_q];

      always_comb begin
        // Link results store the return address, zero-extended then +8
        // (wrapping modulo 2^DATA_W).
        pc_ext                = '0;
        pc_ext[ADDR_W-1:0]    = in_pc[gi*ADDR_W +: ADDR_W];
        enq_data              = in_link[gi] ? (pc_ext + DATA_W'(8))
                                            : in_data[gi*DATA_W +: DATA_W];

        // Anything presented during a flush is dropped.
        push     = in_valid[gi] & ready & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage carries no reset: contents are only observed through the
      // count, which is reset.
      always_ff @(posedge clk) begin
        if (rst_n && push) begin
          mem_data_q[wr_ptr_q] <= enq_data;
          mem_regf_q[wr_ptr_q] <= in_regf[gi*REGF_W +: REGF_W];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // The search order rr_ptr, rr_ptr+1, ..., wrapping, is split into two
  // passes: channels at or above rr_ptr take priority over those below it,
  // and within each pass the lowest index wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic            found_hi;
    logic            found_lo;
    logic [RR_W-1:0] win_hi;
    logic [RR_W-1:0] win_lo;

    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (nonempty[i]) begin
        if (i >= int'(rr_ptr_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = RR_W'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = RR_W'(i);
        end
      end
    end

    have_win = found_hi | found_lo;
    win_idx  = found_hi ? win_hi : win_lo;

    pop_vec  = '0;
    win_regf = '0;
    win_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (have_win && (win_idx == RR_W'(i))) begin
        // A flush discards the head instead of consuming it.
        pop_vec[i] = ~flush;
        win_regf   = head_regf_flat[i*REGF_W +: REGF_W];
        win_data   = head_data_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port registers and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rr_ptr_d   = rr_ptr_q;
    if (!flush && have_win) begin
      // A register-0 entry still consumes its slot but never writes.
      rf_we_d    = (win_regf != '0);
      rf_waddr_d = win_regf;
      rf_wdata_d = win_data;
      rr_ptr_d   = (win_idx == RR_W'(NCH - 1)) ? '0 : (win_idx + RR_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = (|nonempty) | rf_we_q;

  // ---------------------------------------------------------------------------
  // Optional stall counter
  // ---------------------------------------------------------------------------
`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    // Flush does not clear it; it only counts rejected valids.
    if ((|(in_valid & ~in_ready)) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_merge                                                     |
// | Purpose  : Self-checking bench for wb_merge (NCH=2, DEPTH=4). A queue-     |
// |            based reference model predicts every output; directed tasks    |
// |            add explicit constant checks for the key scenarios.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_wb_merge;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  in_valid;
  logic [1:0]  in_link;
  logic [9:0]  in_regf;
  logic [63:0] in_data;
  logic [63:0] in_pc;
  wire  [1:0]  in_ready;
  wire         rf_we;
  wire  [4:0]  rf_waddr;
  wire  [31:0] rf_wdata;
  wire         busy;
`ifdef WB_STALL_CNT_EN
  wire  [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  wb_merge #(
    .NCH(NCH), .DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32), .REGF_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_regf  (in_regf),
    .in_data  (in_data),
    .in_link  (in_link),
    .in_pc    (in_pc),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: one queue of (regf, data) per channel
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq0[$];
  ent_t        mq1[$];
  int          m_rr;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_stall;
  bit          m_init = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic clear_inputs();
    in_valid = '0;
    in_link  = '0;
    flush    = 1'b0;
  endtask

  task automatic drive(input int ch, input logic [4:0] r, input logic [31:0] d,
                       input logic lk, input logic [31:0] pc);
    in_valid[ch]        = 1'b1;
    in_regf[ch*5 +: 5]  = r;
    in_data[ch*32 +: 32] = d;
    in_link[ch]         = lk;
    in_pc[ch*32 +: 32]  = pc;
  endtask

  // One clock cycle: checks state-only outputs against the model, advances
  // the model by the rules of the block, clocks the DUT, and checks the
  // registered outputs.
  task automatic step();
    int          sz[2];
    logic [1:0]  mrdy;
    int          w;
    int          c;
    ent_t        e;
    logic [31:0] dv;

    sz[0] = mq0.size();
    sz[1] = mq1.size();
    for (int i = 0; i < NCH; i++) mrdy[i] = (sz[i] < DEPTH);

    if (m_init) begin
      n_cmp++;
      if (in_ready !== mrdy) begin
        n_fail++;
        $display("FAIL in_ready: got %b expected %b at %0t", in_ready, mrdy, $time);
      end
      n_cmp++;
      if (busy !== ((sz[0] + sz[1] > 0) || m_we)) begin
        n_fail++;
        $display("FAIL busy: got %b expected %b at %0t", busy,
                 ((sz[0] + sz[1] > 0) || m_we), $time);
      end
    end

    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
      m_rr    = 0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_stall = '0;
      m_init  = 1'b1;
    end else begin
      if (((in_valid & ~mrdy) != 2'b00) && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      if (flush) begin
        mq0.delete();
        mq1.delete();
        m_we = 1'b0;
      end else begin
        w = -1;
        for (int k = 0; k < NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (w < 0 && sz[c] > 0) w = c;
        end
        if (w >= 0) begin
          e       = (w == 0) ? mq0.pop_front() : mq1.pop_front();
          m_we    = (e.r != 5'd0);
          m_waddr = e.r;
          m_wdata = e.d;
          m_rr    = (w + 1) % NCH;
        end else begin
          m_we = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
          if (in_valid[i] && mrdy[i]) begin
            dv  = in_link[i] ? (in_pc[i*32 +: 32] + 32'd8) : in_data[i*32 +: 32];
            e.r = in_regf[i*5 +: 5];
            e.d = dv;
            if (i == 0) mq0.push_back(e);
            else        mq1.push_back(e);
          end
        end
      end
    end

    @(posedge clk);
    #1;

    if (m_init) begin
      n_cmp++;
      if (rf_we !== m_we) begin
        n_fail++;
        $display("FAIL rf_we: got %b expected %b at %0t", rf_we, m_we, $time);
      end
      n_cmp++;
      if (rf_waddr !== m_waddr) begin
        n_fail++;
        $display("FAIL rf_waddr: got %0d expected %0d at %0t", rf_waddr, m_waddr, $time);
      end
      n_cmp++;
      if (rf_wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL rf_wdata: got %h expected %h at %0t", rf_wdata, m_wdata, $time);
      end
`ifdef WB_STALL_CNT_EN
      n_cmp++;
      if (stall_cnt !== m_stall) begin
        n_fail++;
        $display("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, m_stall, $time);
      end
`endif
    end
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    in_regf = '0;
    in_data = '0;
    in_pc   = '0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h expected 0/0/0",
               rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++;
    if (in_ready !== 2'b11 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_busy: got ready=%b busy=%b expected 11/0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    clear_inputs();
    drive(0, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1: got rf_we=%b expected 0", rf_we);
    end
    idle(1);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_edge2: got we=%b addr=%0d data=%h expected 1/5/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    idle(1);
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge3: got rf_we=%b expected 0", rf_we);
    end
  endtask

  task automatic test_link();
    clear_inputs();
    drive(1, 5'd31, $urandom, 1'b1, 32'h0040_0010);
    step();
    idle(1);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h0040_0018) begin
      n_fail++;
      $display("FAIL link_basic: got we=%b addr=%0d data=%h expected 1/31/00400018",
               rf_we, rf_waddr, rf_wdata);
    end
    clear_inputs();
    drive(1, 5'd31, $urandom, 1'b1, 32'hFFFF_FFFC);
    step();
    idle(1);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL link_wrap: got we=%b data=%h expected 1/00000004", rf_we, rf_wdata);
    end
    idle(2);
  endtask

  // rr_ptr is 0 here (the last pop was from ch1).
  task automatic test_round_robin();
    logic [4:0] seen[8];
    logic       we_seen[8];
    logic [4:0] exp_addr[6];
    exp_addr[0] = 5'd1;  exp_addr[1] = 5'd17;
    exp_addr[2] = 5'd2;  exp_addr[3] = 5'd18;
    exp_addr[4] = 5'd3;  exp_addr[5] = 5'd19;
    for (int s = 0; s < 8; s++) begin
      clear_inputs();
      if (s < 3) begin
        drive(0, 5'(1 + s),  $urandom, 1'b0, 32'h0);
        drive(1, 5'(17 + s), $urandom, 1'b0, 32'h0);
      end
      step();
      seen[s]    = rf_waddr;
      we_seen[s] = rf_we;
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (we_seen[k+1] !== 1'b1 || seen[k+1] !== exp_addr[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got we=%b addr=%0d expected 1/%0d",
                 k, we_seen[k+1], seen[k+1], exp_addr[k]);
      end
    end
    // Both channels loaded together: ch0 must win first.
    clear_inputs();
    drive(0, 5'd4,  $urandom, 1'b0, 32'h0);
    drive(1, 5'd20, $urandom, 1'b0, 32'h0);
    step();
    idle(1);
    n_cmp++;
    if (rf_waddr !== 5'd4) begin
      n_fail++;
      $display("FAIL rr_restart: got addr=%0d expected 4", rf_waddr);
    end
    idle(3);
  endtask

  task automatic test_full();
    bit saw_full = 1'b0;
    for (int s = 0; s < 14; s++) begin
      clear_inputs();
      drive(0, 5'($urandom_range(0, 3)), $urandom, 1'b0, 32'h0);
      drive(1, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      if (in_ready[0] === 1'b0) saw_full = 1'b1;
      step();
    end
    n_cmp++;
    if (saw_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_backpressure: got saw_full=%b expected 1", saw_full);
    end
    idle(12);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_flush();
`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_before;
`endif
    for (int s = 0; s < 3; s++) begin
      clear_inputs();
      drive(0, 5'($urandom_range(1, 31)), $urandom, 1'b0, 32'h0);
      drive(1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 32'h0);
      step();
    end
`ifdef WB_STALL_CNT_EN
    stall_before = m_stall;
`endif
    flush = 1'b1;
    step();
    clear_inputs();
    n_cmp++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_clear: got we=%b busy=%b ready=%b expected 0/0/11",
               rf_we, busy, in_ready);
    end
`ifdef WB_STALL_CNT_EN
    n_cmp++;
    if (stall_cnt !== stall_before) begin
      n_fail++;
      $display("FAIL flush_stall_hold: got %0d expected %0d", stall_cnt, stall_before);
    end
`endif
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++;
      if (rf_we !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_write: got rf_we=%b expected 0", rf_we);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      clear_inputs();
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 99) < 65) begin
          drive(ch, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                $urandom, 1'($urandom_range(0, 3) == 0), $urandom);
        end
      end
      flush = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      rst_n = 1'b1;
    end
    idle(12);
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    in_regf = '0;
    in_data = '0;
    in_pc   = '0;
    #1;
    test_reset();
    test_single();
    test_link();
    test_round_robin();
    test_full();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_merge.md
Name: wb_merge

Overview:
Parametrised multi-channel writeback stage. It accepts results from NCH independent producers (e.g. ALU/load path, mul/div path) and buffers each in a per-channel FIFO. Round-robin arbitration then drives the register file's single write port. Link-type results (pc+8) are resolved at enqueue, and writes to register 0 are discarded.

Parameters:
NCH, 2, number of producer channels (>=2)
DEPTH, 4, entries per channel FIFO (power of 2, >=2)
DATA_W, 32, result data width
ADDR_W, 32, pc width (<= DATA_W)
REGF_W, 5, register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous clear of all buffered results
in_valid  input  NCH  per-channel result valid
in_ready  output  NCH  per-channel space available
in_regf  input  NCH*REGF_W  destination register; channel i at [i*REGF_W +: REGF_W]
in_data  input  NCH*DATA_W  result data, same packing
in_link  input  NCH  1 = write pc+8 instead of in_data
in_pc  input  NCH*ADDR_W  instruction pc, same packing
rf_we  output  1  register file write enable (registered)
rf_waddr  output  REGF_W  write address (registered)
rf_wdata  output  DATA_W  write data (registered)
busy  output  1  any FIFO non-empty or rf_we high

Behaviour:
- Reset (rst_n=0 at edge): all FIFO counts and pointers 0, rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0. Reset overrides flush and all handshakes.
- in_ready[i] = (count[i] < DEPTH). No pass-through when full: a full FIFO deasserts ready even if it pops this cycle.
- Enqueue on in_valid[i] & in_ready[i]. Stored word = in_link[i] ? zero-extended in_pc + 8 (mod 2^DATA_W) : in_data[i]. in_regf is stored alongside.
- Per-channel FIFO order is preserved. Order across channels is not guaranteed; the hazard unit prevents cross-channel WAW.
- Arbitration is combinational over channels with count>0. Search starts at rr_ptr, ascending and wrapping modulo NCH; the first non-empty channel wins.
- On each edge with a winner w:
  - Pop head of w.
  - rf_waddr <= head regf; rf_wdata <= head data.
  - rf_we <= (head regf != 0).
  - rr_ptr <= (w+1) mod NCH.
- A regf=0 entry is still consumed (one slot) but produces rf_we=0.
- No winner: rf_we <= 0; rf_waddr/rf_wdata hold; rr_ptr holds.
- Latency: an entry accepted at edge k into an empty FIFO is popped at edge k+1, so rf_we is high in the cycle after edge k+1. Minimum latency is 2 cycles.
- Throughput: one write per cycle total. Simultaneous enqueue and dequeue on the same non-full FIFO leaves count unchanged.
- Pointer/count wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- flush=1 at edge:
  - All counts and pointers go to 0; rf_we <= 0; rr_ptr holds.
  - Inputs accepted that cycle are dropped.
  - in_ready is high for all channels the next cycle.
- Reset or flush mid-stream loses buffered entries by design.
- busy is combinational: |count | rf_we.

Optional Feature:
Macro WB_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits).
  - Reset to 0 on rst_n=0.
  - Increments by 1 on each edge where any channel has in_valid & !in_ready.
  - Saturates at 32'hFFFF_FFFF; unaffected by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset held 3 cycles, then released:
  - rf_we=0, rf_waddr=0, rf_wdata=0, in_ready all 1, busy=0.
- Single entry ch0 regf=5 data=32'hDEADBEEF accepted at edge 1:
  - rf_we=1, waddr=5, wdata=DEADBEEF after edge 2 only; rf_we=0 after edge 3.
- Link path ch1 in_link=1 pc=32'h0040_0010 regf=31:
  - Write of 32'h0040_0018 to reg 31.
  - Repeat with pc=32'hFFFF_FFFC: wdata=32'h0000_0004.
- NCH=2, both channels hold 3 entries each:
  - Writes alternate ch0,ch1,ch0,ch1,ch0,ch1 on 6 consecutive cycles.
  - rr_ptr=0 after the last ch1 pop.
- Fill ch0 with DEPTH=4 entries while holding the output busy (ch1 also loaded):
  - in_ready[0]=0 at count 4; a 5th valid is not accepted.
  - Regf=0 entries drain with rf_we=0 and in order.
- Load 2 entries per channel, assert flush one cycle:
  - Next cycle rf_we=0, busy=0, in_ready all 1, no further writes.
  - With WB_STALL_CNT_EN, stall_cnt equals the number of full-stall cycles counted before flush and holds across flush.
